// File: rtl/mips_bus_arbiter.sv
// Two-master (data / instruction fetch) arbiter onto one memory bus; 1 arbitration cycle, then memory waitrequest passes straight through.
// Tie break is fixed data priority unless ARB_ROUND_ROBIN_EN is defined, which alternates against the last completed port.
module mips_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  // data-port master
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  // instruction-fetch master
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  // shared memory bus
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  state_t w_state_eff;
  logic   r_last_grant_i;
  logic   w_last_grant_i_nxt;
  logic   w_d_req;
  logic   w_i_req;
  logic   w_d_wins_tie;

  assign w_d_req = d_read | d_write;
  assign w_i_req = i_read;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_d_wins_tie = r_last_grant_i;
`else
  // last_grant is still tracked here so both builds share identical state
  assign w_d_wins_tie = 1'b1 | r_last_grant_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_grant_i <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_last_grant_i <= w_last_grant_i_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_last_grant_i_nxt = r_last_grant_i;
    case (r_state)
      IDLE: begin
        if (w_d_req && w_i_req) begin
          w_state_nxt = w_d_wins_tie ? GNT_D : GNT_I;
        end else if (w_d_req) begin
          w_state_nxt = GNT_D;
        end else if (w_i_req) begin
          w_state_nxt = GNT_I;
        end
      end
      GNT_D: begin
        if (!w_d_req) begin
          w_state_nxt = IDLE;
        end else if (!waitrequest) begin
          w_state_nxt        = IDLE;
          w_last_grant_i_nxt = 1'b0;
        end
      end
      GNT_I: begin
        if (!w_i_req) begin
          w_state_nxt = IDLE;
        end else if (!waitrequest) begin
          w_state_nxt        = IDLE;
          w_last_grant_i_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset forces idle outputs in the very cycle it is asserted, not only after the edge
  always_comb begin
    w_state_eff = r_state;
    if (reset) begin
      w_state_eff = IDLE;
    end
  end

  always_comb begin
    address       = 32'd0;
    writedata     = 32'd0;
    read          = 1'b0;
    write         = 1'b0;
    byteenable    = 4'd0;
    d_waitrequest = 1'b1;
    d_readdata    = 32'd0;
    i_waitrequest = 1'b1;
    i_readdata    = 32'd0;
    grant         = 2'b00;
    case (w_state_eff)
      GNT_D: begin
        address       = d_address;
        writedata     = d_writedata;
        // simultaneous read+write from the data master is handled as a write
        read          = d_read & ~d_write;
        write         = d_write;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
        d_readdata    = readdata;
        grant         = 2'b01;
      end
      GNT_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = 4'b1111;
        i_waitrequest = waitrequest;
        i_readdata    = readdata;
        grant         = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboarded bench for mips_bus_arbiter: cycle reference model feeds an expected-output queue, monitor compares on negedge.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_address, d_writedata, d_readdata;
  logic        d_read, d_write, d_waitrequest;
  logic [3:0]  d_byteenable;
  logic [31:0] i_address, i_readdata;
  logic        i_read, i_waitrequest;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;
  logic [1:0]  grant;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .d_address(d_address), .d_writedata(d_writedata), .d_read(d_read), .d_write(d_write),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .address(address), .writedata(writedata), .read(read), .write(write),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] writedata;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic        dwait;
    logic [31:0] drd;
    logic        iwait;
    logic [31:0] ird;
    logic [1:0]  grant;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   log_port[$];
  int   log_cyc[$];
  logic [31:0] log_dat[$];
  int   wr_cycles = 0;
  logic d_fin = 1'b0;
  logic i_fin = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: who owns the bus this cycle (0 none, 1 data, 2 instruction)
  initial begin
    int   owner;
    bit   last_i;
    bit   dq, iq;
    obs_t e;
    owner  = 0;
    last_i = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      dq = d_read || d_write;
      iq = i_read;
      e = '0;
      e.dwait = 1'b1;
      e.iwait = 1'b1;
      if (!reset && owner == 1) begin
        e.address    = d_address;
        e.writedata  = d_writedata;
        e.byteenable = d_byteenable;
        e.write      = d_write;
        e.read       = d_read && !d_write;
        e.dwait      = waitrequest;
        e.drd        = readdata;
        e.grant      = 2'b01;
      end else if (!reset && owner == 2) begin
        e.address    = i_address;
        e.byteenable = 4'hF;
        e.read       = i_read;
        e.iwait      = waitrequest;
        e.ird        = readdata;
        e.grant      = 2'b10;
      end
      exp_q.push_back(e);
      if (reset) begin
        owner  = 0;
        last_i = 1'b1;
      end else if (owner == 0) begin
        if (dq && iq) begin
`ifdef ARB_ROUND_ROBIN_EN
          owner = last_i ? 1 : 2;
`else
          owner = 1;
`endif
        end else if (dq) owner = 1;
        else if (iq) owner = 2;
      end else if (owner == 1) begin
        if (!dq) owner = 0;
        else if (!waitrequest) begin owner = 0; last_i = 1'b0; end
      end else begin
        if (!iq) owner = 0;
        else if (!waitrequest) begin owner = 0; last_i = 1'b1; end
      end
    end
  end

  // Monitor: pop one expectation per cycle, compare, and log observed completions
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      a.address = address;   a.writedata = writedata; a.read = read; a.write = write;
      a.byteenable = byteenable; a.dwait = d_waitrequest; a.drd = d_readdata;
      a.iwait = i_waitrequest; a.ird = i_readdata; a.grant = grant;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty cycle=%0d got=%h want=<none>", cyc, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL bus_outputs cycle=%0d got=%h want=%h", cyc, a, e);
        end
      end
      d_fin = (d_read || d_write) && !d_waitrequest;
      i_fin = i_read && !i_waitrequest;
      if (d_fin) begin log_port.push_back(1); log_cyc.push_back(cyc); log_dat.push_back(d_readdata); end
      if (i_fin) begin log_port.push_back(2); log_cyc.push_back(cyc); log_dat.push_back(i_readdata); end
      if (write) wr_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_port.delete();
    log_cyc.delete();
    log_dat.delete();
    wr_cycles = 0;
  endtask

  initial begin
    int s;
    int exp_tie[4];
    bit d_act, i_act;
    int op;
    reset = 1'b1;
    d_address = 0; d_writedata = 0; d_read = 0; d_write = 0; d_byteenable = 0;
    i_address = 0; i_read = 0; waitrequest = 0; readdata = 32'h1234_5678;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // single instruction fetch
    clear_log();
    i_read = 1'b1; i_address = 32'hBFC0_0000; waitrequest = 1'b0; readdata = 32'h2402_0006;
    s = cyc;
    tick();
    tick(); i_read = 1'b0;
    tick();
    chk("fetch_count", log_port.size(), 1);
    if (log_port.size() >= 1) begin
      chk("fetch_port", log_port[0], 2);
      chk("fetch_latency", log_cyc[0] - s, 1);
      chk("fetch_data", log_dat[0], 32'h2402_0006);
    end

    // data write stalled three cycles
    clear_log();
    d_write = 1'b1; d_address = 32'h0000_1000; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
    waitrequest = 1'b1;
    s = cyc;
    repeat (3) tick();
    tick(); waitrequest = 1'b0;
    tick(); d_write = 1'b0;
    tick();
    chk("wr_count", log_port.size(), 1);
    chk("wr_hold_cycles", wr_cycles, 4);
    if (log_port.size() >= 1) chk("wr_latency", log_cyc[0] - s, 4);

    // continuous tie from a fresh reset
`ifdef ARB_ROUND_ROBIN_EN
    exp_tie = '{1, 2, 1, 2};
`else
    exp_tie = '{1, 1, 1, 1};
`endif
    reset = 1'b1;
    tick();
    clear_log();
    reset = 1'b0; d_read = 1'b1; d_address = 32'h0000_2000; d_byteenable = 4'hF;
    i_read = 1'b1; i_address = 32'hBFC0_0004; readdata = 32'hA5A5_0001; waitrequest = 1'b0;
    s = cyc;
    repeat (7) tick();
    tick(); d_read = 1'b0; i_read = 1'b0;
    tick();
    chk("tie_count", log_port.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < log_port.size()) begin
        chk("tie_port", log_port[k], exp_tie[k]);
        chk("tie_cycle", log_cyc[k] - s, 2 * k + 1);
      end
    end

    // reset while data write is stalled, instruction fetch pending
    clear_log();
    d_write = 1'b1; d_address = 32'h0000_3000; waitrequest = 1'b1;
    tick();
    tick(); reset = 1'b1; d_write = 1'b0; i_read = 1'b1; i_address = 32'hBFC0_0008;
    tick(); reset = 1'b0; waitrequest = 1'b0;
    #3;
    chk("rst_grant", grant, 0);
    chk("rst_write", write, 0);
    chk("rst_dwait", d_waitrequest, 1);
    tick();
    tick(); i_read = 1'b0;
    tick();
    chk("rst_count", log_port.size(), 1);
    if (log_port.size() >= 1) chk("rst_first_port", log_port[0], 2);

    // instruction fetch aborted while stalled
    clear_log();
    i_read = 1'b1; i_address = 32'hBFC0_000C; waitrequest = 1'b1;
    tick();
    tick(); i_read = 1'b0;
    #3;
    chk("abort_grant", grant, 2);
    chk("abort_read", read, 0);
    tick();
    #3;
    chk("abort_idle_grant", grant, 0);
    tick();
    chk("abort_count", log_port.size(), 0);

    // randomized traffic with aborts and occasional resets
    d_act = 0; i_act = 0;
    repeat (3000) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if (d_act && (d_fin || $urandom_range(0, 23) == 0)) d_act = 0;
      if (i_act && (i_fin || $urandom_range(0, 23) == 0)) i_act = 0;
      if (reset) begin d_act = 0; i_act = 0; end
      if (!d_act && !reset && $urandom_range(0, 2) == 0) begin
        d_act = 1;
        d_address = $urandom; d_writedata = $urandom; d_byteenable = 4'($urandom_range(0, 15));
        op = $urandom_range(0, 9);
        d_read  = (op <= 4) || (op == 9);
        d_write = (op >= 5);
      end
      if (!d_act) begin d_read = 1'b0; d_write = 1'b0; end
      if (!i_act && !reset && $urandom_range(0, 2) == 0) begin
        i_act = 1;
        i_address = $urandom;
      end
      i_read = i_act;
      waitrequest = ($urandom_range(0, 2) == 0);
      readdata = $urandom;
    end

    reset = 1'b0; d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter: none; the only configuration is by macro (see Configuration).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 d_address, d_writedata  input  32 each  data-port master request address and write data.
REQ-005 d_read, d_write  input  1 each  data-port master request strobes.
REQ-006 d_byteenable  input  4  data-port byte lanes.
REQ-007 d_waitrequest  output  1  data-port stall; d_readdata  output  32  data-port read data.
REQ-008 i_address  input  32; i_read  input  1  instruction-fetch master (read-only, byteenable fixed 4'b1111).
REQ-009 i_waitrequest  output  1; i_readdata  output  32  instruction-port stall and read data.
REQ-010 address, writedata  output  32 each; read, write  output  1 each; byteenable  output  4  shared memory bus to RAM.
REQ-011 waitrequest  input  1; readdata  input  32  memory stall and read data.
REQ-012 grant  output  2  debug: 2'b00 none, 2'b01 data, 2'b10 instruction.

Function
REQ-013 States: IDLE, GNT_D, GNT_I; state register updates only on posedge clk.
REQ-014 Request: d_req = d_read|d_write; i_req = i_read; d_read&d_write together is a protocol error treated as a write.
REQ-015 IDLE: memory read=write=0; d_waitrequest=i_waitrequest=1; grant=00.
REQ-016 IDLE, one requester: next state grants it; both requesting: winner per Configuration.
REQ-017 GNT_D: memory bus = data-port signals combinationally; d_waitrequest=waitrequest; d_readdata=readdata; i_waitrequest=1; grant=01.
REQ-018 GNT_I: memory address=i_address, read=i_read, write=0, byteenable=4'b1111, writedata=0; i_waitrequest=waitrequest; i_readdata=readdata; d_waitrequest=1; grant=10.
REQ-019 Completion: cycle in GNT_x with x request high and waitrequest low; readdata valid that cycle; next state IDLE.
REQ-020 Latency: minimum 2 cycles request-to-completion (1 arbitration cycle + 1 memory cycle); each extra waitrequest cycle adds 1.
REQ-021 Granted master drops request before completion (abort): next state IDLE, no memory strobe driven that cycle.
REQ-022 Non-granted master's readdata output holds 0; its waitrequest stays 1 until granted.
REQ-023 Masters shall hold request signals stable while their waitrequest is 1; arbiter does not latch master signals.
REQ-024 last_grant register (1 bit) records port of the most recent completion; reset to instruction so data wins first tie.

Reset
REQ-025 reset high at posedge: state=IDLE, last_grant=instruction, independent of current state, including mid-transaction.
REQ-026 During and after reset until next grant: read=write=0, grant=00, d_waitrequest=i_waitrequest=1, d_readdata=i_readdata=0.
REQ-027 A transaction in flight at reset is dropped; memory-side waitrequest is ignored in IDLE.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: on tie in IDLE, grant the port opposite last_grant.
REQ-029 Macro undefined: on tie, data port always wins (fixed priority); last_grant still maintained but unused.

Verification
REQ-030 Single fetch: i_read=1, i_address=0xBFC00000, RAM waitrequest=0, readdata=0x24020006 -> grant=10 on cycle 2, i_waitrequest=0 and i_readdata=0x24020006 that cycle, IDLE cycle 3.
REQ-031 Data write with stall: d_write=1, d_address=0x00001000, d_writedata=0xDEADBEEF, d_byteenable=4'b0011, waitrequest=1 for 3 cycles -> memory write held 4 cycles with same values, d_waitrequest falls on cycle 5.
REQ-032 Tie, macro defined: d_read and i_read held continuously -> completions alternate D,I,D,I over 4 transactions, 2 cycles each.
REQ-033 Tie, macro undefined: same stimulus -> data completes every 2 cycles, i_waitrequest stays 1 throughout.
REQ-034 Reset mid-grant: reset asserted in GNT_D with waitrequest=1 -> next cycle grant=00, write=0, d_waitrequest=1; after reset release, pending i_read granted first.
REQ-035 Abort: i_read dropped in GNT_I while waitrequest=1 -> next cycle IDLE, read=0, no completion recorded.
